// File: rtl/fetch_stage_ctrl.sv
// Instruction-fetch controller: owns the PC, issues single-outstanding imem
// requests and drives the IF/ID pipeline register under stall/flush/redirect.
module fetch_stage_ctrl #(
   parameter int unsigned     XLEN      = 32,
   parameter logic [XLEN-1:0] RESET_PC  = '0,
   parameter logic [31:0]     NOP_INSTR = 32'h0000_0013
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            stall,
   input  logic            if_id_flush,
   input  logic            redirect_valid,
   input  logic [XLEN-1:0] redirect_pc,
   output logic            imem_req,
   output logic [XLEN-1:0] imem_addr,
   input  logic            imem_rvalid,
   input  logic [31:0]     imem_rdata,
   output logic [XLEN-1:0] pc_current,
   output logic            if_id_valid,
   output logic [XLEN-1:0] if_id_pc,
   output logic [31:0]     if_id_instr
);

   localparam int unsigned ILEN    = 32;
   localparam int unsigned PC_STEP = 4;

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_FETCH = 3'd1,
      S_WAIT  = 3'd2,
      S_HOLD  = 3'd3,
      S_DROP  = 3'd4
   } state_t;

   state_t            state_q;
   state_t            state_d;
   logic [ILEN-1:0]   hold_q;
   logic              accept_c;
   logic              capture_c;
   logic              hold_release_c;
   logic              enter_c;
   logic [ILEN-1:0]   enter_word_c;

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= S_IDLE;
      else        state_q <= state_d;
   end

   // Next state plus the strobes that move instruction words around
   always_comb begin
      state_d        = state_q;
      accept_c       = 1'b0;
      capture_c      = 1'b0;
      hold_release_c = 1'b0;
      case (state_q)
         S_IDLE:  state_d = S_FETCH;
         S_FETCH: state_d = redirect_valid ? S_DROP : S_WAIT;
         S_WAIT: begin
            if (imem_rvalid) begin
               state_d = S_FETCH;
               if (!redirect_valid && !if_id_flush) begin
                  if (stall) begin
                     state_d   = S_HOLD;
                     capture_c = 1'b1;
                  end else begin
                     accept_c = 1'b1;
                  end
               end
            end else if (redirect_valid) begin
               state_d = S_DROP;
            end
         end
         S_HOLD: begin
            if (redirect_valid || if_id_flush) begin
               state_d = S_FETCH;
            end else if (!stall) begin
               state_d        = S_FETCH;
               hold_release_c = 1'b1;
            end
         end
         // A stale response is still owed; it ends DROP even if redirected again
         S_DROP:  if (imem_rvalid) state_d = S_FETCH;
         default: state_d = S_IDLE;
      endcase
   end

   // Memory request decode
   always_comb begin
      imem_req  = 1'b0;
      imem_addr = pc_current;
      if (state_q == S_FETCH) imem_req = 1'b1;
   end

   assign enter_c      = accept_c | hold_release_c;
   assign enter_word_c = accept_c ? imem_rdata : hold_q;

   // PC: redirect beats the sequential increment
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc_current <= RESET_PC;
      end else if (redirect_valid) begin
         pc_current <= redirect_pc & ~XLEN'(3);
      end else if (enter_c) begin
         pc_current <= pc_current + XLEN'(PC_STEP);
      end
   end

   // Response captured while decode is stalled
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)         hold_q <= '0;
      else if (capture_c) hold_q <= imem_rdata;
   end

   // IF/ID register: flush clears, stall holds, otherwise a bubble when empty
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         if_id_valid <= 1'b0;
         if_id_pc    <= '0;
         if_id_instr <= NOP_INSTR;
      end else if (if_id_flush) begin
         if_id_valid <= 1'b0;
         if_id_instr <= NOP_INSTR;
      end else if (enter_c) begin
         if_id_valid <= 1'b1;
         if_id_pc    <= pc_current;
         if_id_instr <= enter_word_c;
      end else if (!stall) begin
         if_id_valid <= 1'b0;
         if_id_instr <= NOP_INSTR;
      end
   end

endmodule

// File: tb/tb_fetch_stage_ctrl.sv
// Directed and random bench for fetch_stage_ctrl against a flag-based
// transaction model of the fetch protocol and a variable-latency memory.
module tb_fetch_stage_ctrl;

   localparam logic [31:0] NOP = 32'h0000_0013;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        stall = 1'b0;
   logic        if_id_flush = 1'b0;
   logic        redirect_valid = 1'b0;
   logic [31:0] redirect_pc = '0;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_rvalid = 1'b0;
   logic [31:0] imem_rdata = '0;
   logic [31:0] pc_current;
   logic        if_id_valid;
   logic [31:0] if_id_pc;
   logic [31:0] if_id_instr;

   fetch_stage_ctrl dut (
      .clk(clk), .rst_n(rst_n), .stall(stall), .if_id_flush(if_id_flush),
      .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
      .imem_req(imem_req), .imem_addr(imem_addr),
      .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
      .pc_current(pc_current), .if_id_valid(if_id_valid),
      .if_id_pc(if_id_pc), .if_id_instr(if_id_instr)
   );

   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;

   // Model: where the fetch transaction stands, not how the RTL encodes it
   bit          m_started, m_issue, m_wait, m_drop, m_held, m_ifv;
   logic [31:0] m_hword, m_pc, m_ifpc, m_ifi;

   int          mem_cnt;
   int          mem_lat;
   bit          mem_rand;
   logic [31:0] mem_addr;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      case (a)
         32'h0000_0000: return 32'h00A0_0093;
         32'h0000_0004: return 32'h0010_0113;
         default:       return (a * 32'h9E37_79B1) ^ 32'h0000_0013;
      endcase
   endfunction

   task automatic model_reset();
      m_started = 0; m_issue = 0; m_wait = 0; m_drop = 0; m_held = 0;
      m_ifv = 0; m_hword = '0; m_pc = '0; m_ifpc = '0; m_ifi = NOP;
      mem_cnt = 0; imem_rvalid = 1'b0;
   endtask

   task automatic model_step(input bit s, input bit f, input bit r,
                             input logic [31:0] rpc, input bit rv,
                             input logic [31:0] rd);
      bit          enter;
      logic [31:0] eword;
      enter = 0;
      eword = '0;
      if (!m_started) begin
         m_started = 1;
         m_issue   = 1;
      end else if (m_issue) begin
         m_issue = 0;
         if (r) m_drop = 1;
         else   m_wait = 1;
      end else if (m_wait) begin
         if (rv) begin
            m_wait = 0;
            if (r || f) m_issue = 1;
            else if (s) begin
               m_held  = 1;
               m_hword = rd;
            end else begin
               enter   = 1;
               eword   = rd;
               m_issue = 1;
            end
         end else if (r) begin
            m_wait = 0;
            m_drop = 1;
         end
      end else if (m_drop) begin
         if (rv) begin
            m_drop  = 0;
            m_issue = 1;
         end
      end else if (m_held) begin
         if (r || f) begin
            m_held  = 0;
            m_issue = 1;
         end else if (!s) begin
            m_held  = 0;
            enter   = 1;
            eword   = m_hword;
            m_issue = 1;
         end
      end
      if (f) begin
         m_ifv = 0;
         m_ifi = NOP;
      end else if (enter) begin
         m_ifv  = 1;
         m_ifpc = m_pc;
         m_ifi  = eword;
      end else if (!s) begin
         m_ifv = 0;
         m_ifi = NOP;
      end
      if (r)          m_pc = {rpc[31:2], 2'b00};
      else if (enter) m_pc = m_pc + 32'd4;
   endtask

   // Memory: answers each request after 1..3 cycles
   task automatic mem_update();
      imem_rvalid = 1'b0;
      if (mem_cnt != 0) begin
         if (mem_cnt == 1) begin
            imem_rvalid = 1'b1;
            imem_rdata  = mem_word(mem_addr);
         end
         mem_cnt--;
      end
      if (imem_req) begin
         mem_cnt  = mem_rand ? int'($urandom_range(3, 1)) : mem_lat;
         mem_addr = imem_addr;
      end
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic check_model();
      chk("imem_req",    32'(imem_req),    32'(m_issue));
      chk("imem_addr",   imem_addr,        m_pc);
      chk("pc_current",  pc_current,       m_pc);
      chk("if_id_valid", 32'(if_id_valid), 32'(m_ifv));
      chk("if_id_pc",    if_id_pc,         m_ifpc);
      chk("if_id_instr", if_id_instr,      m_ifi);
   endtask

   task automatic step(input bit s, input bit f, input bit r, input logic [31:0] rpc);
      stall          = s;
      if_id_flush    = f;
      redirect_valid = r;
      redirect_pc    = rpc;
      model_step(s, f, r, rpc, imem_rvalid, imem_rdata);
      @(posedge clk);
      @(negedge clk);
      stall          = 1'b0;
      if_id_flush    = 1'b0;
      redirect_valid = 1'b0;
      mem_update();
      check_model();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   initial begin
      bit found;
      model_reset();
      mem_lat  = 1;
      mem_rand = 0;

      // Reset values while held in reset
      #12;
      check_model();
      chk("rst_instr", if_id_instr, 32'h0000_0013);
      @(negedge clk);
      rst_n = 1'b1;
      mem_update();
      check_model();

      // First fetch: req at 0 after IDLE, IF/ID two cycles later
      step(0, 0, 0, '0);
      chk("first_req", 32'(imem_req), 32'd1);
      chk("first_addr", imem_addr, 32'h0);
      step(0, 0, 0, '0);
      step(0, 0, 0, '0);
      chk("first_valid", 32'(if_id_valid), 32'd1);
      chk("first_pc", if_id_pc, 32'h0);
      chk("first_instr", if_id_instr, 32'h00A0_0093);
      chk("second_addr", imem_addr, 32'h4);

      // Stall across the response: word parked, IF/ID frozen
      repeat (4) step(1, 0, 0, '0);
      chk("stall_instr", if_id_instr, 32'h00A0_0093);
      chk("stall_valid", 32'(if_id_valid), 32'd1);
      chk("stall_noreq", 32'(imem_req), 32'd0);
      step(0, 0, 0, '0);
      chk("release_instr", if_id_instr, 32'h0010_0113);
      chk("release_pc", if_id_pc, 32'h4);
      chk("release_pcc", pc_current, 32'h8);
      chk("release_req", 32'(imem_req), 32'd1);

      // Redirect during FETCH: stale response dropped
      step(0, 0, 1, 32'h0000_0100);
      chk("redir_pc", pc_current, 32'h100);
      step(0, 0, 0, '0);
      chk("redir_dropped", 32'(if_id_valid), 32'd0);
      chk("redir_req", 32'(imem_req), 32'd1);
      chk("redir_addr", imem_addr, 32'h100);

      // Flush with stall and arriving response
      step(0, 0, 0, '0);
      step(1, 1, 0, '0);
      chk("flush_valid", 32'(if_id_valid), 32'd0);
      chk("flush_instr", if_id_instr, 32'h0000_0013);
      chk("flush_pc", pc_current, 32'h100);
      chk("flush_refetch", imem_addr, 32'h100);

      // Redirect to the top word (low bits masked), then wrap
      step(0, 0, 1, 32'hFFFF_FFFF);
      chk("mask_pc", pc_current, 32'hFFFF_FFFC);
      found = 0;
      for (int i = 0; i < 20 && !found; i++) begin
         step(0, 0, 0, '0);
         if (if_id_valid && if_id_pc == 32'hFFFF_FFFC) found = 1;
      end
      chk("wrap_found", 32'(found), 32'd1);
      chk("wrap_pc", pc_current, 32'h0);

      // Asynchronous reset in WAIT
      mem_lat = 3;
      step(0, 0, 0, '0);
      #2 rst_n = 1'b0;
      #1;
      model_reset();
      check_model();
      chk("arst_req", 32'(imem_req), 32'd0);
      chk("arst_pc", pc_current, 32'h0);
      @(posedge clk);
      @(negedge clk);
      rst_n   = 1'b1;
      mem_lat = 1;
      mem_update();
      check_model();
      step(0, 0, 0, '0);
      chk("restart_req", 32'(imem_req), 32'd1);
      chk("restart_addr", imem_addr, 32'h0);

      // Random hazard traffic against the model
      mem_rand = 1;
      repeat (3000)
         step($urandom_range(3, 0) == 0, $urandom_range(9, 0) == 0,
              $urandom_range(9, 0) == 0, $urandom);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
